// File: rtl/seq_pkg.sv
// Shared definitions for the multi-cycle control sequencer.
// Holds the 4-bit opcode encodings, the FSM state type, the write-back mux
// select codes and the opcode class used by the decoder and the FSM.
package seq_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0011;
    localparam logic [3:0] OP_LI    = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // write-back source select
    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_MEM = 2'b01;
    localparam logic [1:0] MUX_IMM = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU   = 3'd0,
        CLS_LOAD  = 3'd1,
        CLS_STORE = 3'd2,
        CLS_LI    = 3'd3,
        CLS_NOP   = 3'd4,
        CLS_HALT  = 3'd5
    } op_class_t;

    // Any opcode outside the named set behaves as a NOP.
    function automatic op_class_t classify(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB: classify = CLS_ALU;
            OP_LOAD:        classify = CLS_LOAD;
            OP_STORE:       classify = CLS_STORE;
            OP_LI:          classify = CLS_LI;
            OP_HALT:        classify = CLS_HALT;
            default:        classify = CLS_NOP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_sequencer_op_decode.sv
// Combinational instruction decoder.
// Ports:
//   ir          in   4  latched instruction opcode
//   op_class    out  3  instruction class (ALU, LOAD, STORE, LI, NOP, HALT)
//   alu_op      out  1  0 = add, 1 = sub (only SUB selects subtract)
//   wb_mux_sel  out  2  write-back source for this instruction
import seq_pkg::*;

module op_decode (
    input  logic [3:0] ir,
    output op_class_t  op_class,
    output logic       alu_op,
    output logic [1:0] wb_mux_sel
);

    always_comb begin
        op_class   = classify(ir);
        alu_op     = 1'b0;
        wb_mux_sel = MUX_ALU;
        case (op_class)
            CLS_ALU:  alu_op     = (ir == OP_SUB);
            CLS_LOAD: wb_mux_sel = MUX_MEM;
            CLS_LI:   wb_mux_sel = MUX_IMM;
            default:  ;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 4-bit-opcode datapath.
// Fetches one opcode per instruction, then walks it through DECODE, EXEC,
// MEM and WB, driving the datapath strobes as Moore decodes of state + IR.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   run               level enable for starting the next instruction
//   fetch_req         out  request to instruction memory (FETCH)
//   fetch_valid/opcode in  instruction memory response
//   mem_ack           in   data memory access complete
//   reg_write_enable, alu_op, mem_read, mem_write, mux_sel  datapath strobes
//   pc_inc            out  one-cycle PC increment (DECODE)
//   busy, halted      out  status
//   mem_error         out  sticky memory-timeout flag
//   retired_count     out  retired instruction count, wraps
// MEM_TIMEOUT must be at least 1.
import seq_pkg::*;

module multicycle_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             fetch_req,
    input  logic             fetch_valid,
    input  logic [3:0]       fetch_opcode,
    input  logic             mem_ack,
    output logic             reg_write_enable,
    output logic             alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       mux_sel,
    output logic             pc_inc,
    output logic             busy,
    output logic             halted,
    output logic             mem_error,
    output logic [CNT_W-1:0] retired_count
);

    // The wait counter reaches at most MEM_TIMEOUT before MEM is left.
    localparam int unsigned      WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [3:0]        ir;
    logic [WAIT_W-1:0] wait_cnt;
    logic              retire;
    logic              timeout;

    op_class_t         op_class;
    logic              dec_alu_op;
    logic [1:0]        dec_mux_sel;

    op_decode u_op_decode (
        .ir         (ir),
        .op_class   (op_class),
        .alu_op     (dec_alu_op),
        .wb_mux_sel (dec_mux_sel)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_valid) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                case (op_class)
                    CLS_ALU, CLS_LI:     state_nxt = S_WB;
                    CLS_LOAD, CLS_STORE: state_nxt = S_MEM;
                    CLS_HALT:            state_nxt = S_HALT;
                    default:             retire    = 1'b1;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (op_class == CLS_LOAD) state_nxt = S_WB;
                    else                      retire    = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            S_WB: begin
                retire = 1'b1;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // run is only consulted at retire, so dropping it mid-instruction
        // lets the current instruction finish.
        if (retire) state_nxt = run ? S_FETCH : S_IDLE;
    end

    // ---------------- Moore outputs ----------------
    always_comb begin
        fetch_req        = 1'b0;
        pc_inc           = 1'b0;
        reg_write_enable = 1'b0;
        alu_op           = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        mux_sel          = MUX_ALU;
        case (state)
            S_FETCH:  fetch_req = 1'b1;
            S_DECODE: pc_inc    = 1'b1;
            S_EXEC: begin
                // LOAD/STORE address add: alu_op and mux_sel stay at 0
                if (op_class == CLS_ALU || op_class == CLS_LI) alu_op = dec_alu_op;
            end
            S_MEM: begin
                mem_read  = (op_class == CLS_LOAD);
                mem_write = (op_class == CLS_STORE);
            end
            S_WB: begin
                reg_write_enable = 1'b1;
                alu_op           = dec_alu_op;
                mux_sel          = dec_mux_sel;
            end
            default: ;
        endcase
    end

    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir <= 4'd0;
        end else if (state == S_FETCH && fetch_valid) begin
            ir <= fetch_opcode;
        end
    end

    // Held at zero outside MEM so it is clear on MEM entry; counts MEM
    // cycles that pass without an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != S_MEM) begin
            wait_cnt <= '0;
        end else if (!mem_ack) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_count <= '0;
        end else if (retire) begin
            retired_count <= retired_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_error <= 1'b0;
        end else if (timeout) begin
            mem_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer (MEM_TIMEOUT = 4, CNT_W = 2).
// The reference model expands each instruction into its expected per-cycle
// schedule of inputs and strobes; each test task replays its schedule.
module tb_multicycle_sequencer;

    localparam int TO = 4;
    localparam int CW = 2;

    localparam bit [3:0] ADD = 4'd0, SUB = 4'd1, LOAD = 4'd2, STORE = 4'd3, LI = 4'd4, HALT = 4'd15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic          fetch_valid = 1'b0;
    logic [3:0]    fetch_opcode = 4'd0;
    logic          mem_ack = 1'b0;
    logic          fetch_req, reg_write_enable, alu_op, mem_read, mem_write;
    logic [1:0]    mux_sel;
    logic          pc_inc, busy, halted, mem_error;
    logic [CW-1:0] retired_count;
    logic [9:0]    outs;

    multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .run              (run),
        .fetch_req        (fetch_req),
        .fetch_valid      (fetch_valid),
        .fetch_opcode     (fetch_opcode),
        .mem_ack          (mem_ack),
        .reg_write_enable (reg_write_enable),
        .alu_op           (alu_op),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mux_sel          (mux_sel),
        .pc_inc           (pc_inc),
        .busy             (busy),
        .halted           (halted),
        .mem_error        (mem_error),
        .retired_count    (retired_count)
    );

    always #5 clk = ~clk;

    assign outs = {fetch_req, pc_inc, reg_write_enable, alu_op, mem_read, mem_write, mux_sel, busy, halted};

    int tot = 0;
    int bad = 0;

    typedef struct {
        bit       run;
        bit       fv;
        bit [3:0] op;
        bit       ack;
        bit [9:0] o;
        bit       err;
        int       cnt;
    } cyc_t;

    cyc_t q[$];
    int   m_cnt;
    bit   m_err;
    bit   m_halt;

    function automatic bit [9:0] ov(bit fr, bit pc, bit we, bit alu, bit mr, bit mw,
                                    bit [1:0] ms, bit bz, bit h);
        return {fr, pc, we, alu, mr, mw, ms, bz, h};
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic push(input bit r, input bit fv, input bit [3:0] op, input bit ack, input bit [9:0] o);
        cyc_t c;
        c.run = r; c.fv = fv; c.op = op; c.ack = ack; c.o = o;
        c.err = m_err; c.cnt = m_cnt;
        q.push_back(c);
    endtask

    // Expected schedule of one instruction. ackk = MEM cycle carrying the ack
    // (anything above TO means the access never completes).
    task automatic model_instr(input bit [3:0] op, input int fw, input int ackk, input bit r);
        bit is_alu, is_ld, is_st, is_li;
        is_alu = (op == ADD) || (op == SUB);
        is_ld  = (op == LOAD);
        is_st  = (op == STORE);
        is_li  = (op == LI);
        for (int i = 0; i < fw; i++) push(r, 1'b0, rop(), rb(), ov(1,0,0,0,0,0,2'b00,1,0));
        push(r, 1'b1, op, rb(), ov(1,0,0,0,0,0,2'b00,1,0));
        push(r, rb(), rop(), rb(), ov(0,1,0,0,0,0,2'b00,1,0));
        push(r, rb(), rop(), rb(), ov(0,0,0,op == SUB,0,0,2'b00,1,0));
        if (op == HALT) begin
            m_halt = 1'b1;
            return;
        end
        if (is_ld || is_st) begin
            for (int k = 1; k <= TO && k <= ackk; k++)
                push(r, rb(), rop(), k == ackk, ov(0,0,0,0,is_ld,is_st,2'b00,1,0));
            if (ackk > TO) begin
                m_err  = 1'b1;
                m_halt = 1'b1;
                return;
            end
            if (is_st) begin
                m_cnt = (m_cnt + 1) % (1 << CW);
                return;
            end
        end else if (!is_alu && !is_li) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            return;
        end
        push(r, rb(), rop(), rb(), ov(0,0,1,op == SUB,0,0, is_ld ? 2'b01 : (is_li ? 2'b10 : 2'b00),1,0));
        m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; fetch_valid = 1'b0; fetch_opcode = 4'd0; mem_ack = 1'b0;
        m_cnt = 0; m_err = 1'b0; m_halt = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tot++;
        if (outs !== 10'd0 || mem_error !== 1'b0 || retired_count !== 2'd0) begin
            bad++; $display("FAIL reset_values got=%b/%b/%0d want=0/0/0", outs, mem_error, retired_count);
        end
        do_reset();
        push(1'b0, rb(), rop(), rb(), 10'd0);
        push(1'b0, rb(), rop(), rb(), 10'd0);
        push(1'b1, rb(), rop(), rb(), 10'd0);
        model_instr(ADD, 1, 1, 1'b0);
        push(1'b0, rb(), rop(), rb(), 10'd0);
        foreach (q[i]) begin
            run = q[i].run; fetch_valid = q[i].fv; fetch_opcode = q[i].op; mem_ack = q[i].ack;
            @(negedge clk);
            tot++;
            if (outs !== q[i].o) begin bad++; $display("FAIL reset_idle cyc=%0d strobes got=%b want=%b", i, outs, q[i].o); end
            tot++;
            if (mem_error !== q[i].err || retired_count !== CW'(q[i].cnt)) begin
                bad++; $display("FAIL reset_idle cyc=%0d err/cnt got=%b/%0d want=%b/%0d", i, mem_error, retired_count, q[i].err, q[i].cnt);
            end
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    task automatic test_add_sub();
        do_reset();
        push(1'b1, 1'b1, ADD, 1'b0, 10'd0);
        model_instr(ADD, 0, 1, 1'b1);
        model_instr(SUB, 0, 1, 1'b1);
        push(1'b1, 1'b0, ADD, 1'b0, ov(1,0,0,0,0,0,2'b00,1,0));
        foreach (q[i]) begin
            run = q[i].run; fetch_valid = q[i].fv; fetch_opcode = q[i].op; mem_ack = q[i].ack;
            @(negedge clk);
            tot++;
            if (outs !== q[i].o) begin bad++; $display("FAIL add_sub cyc=%0d strobes got=%b want=%b", i, outs, q[i].o); end
            tot++;
            if (mem_error !== q[i].err || retired_count !== CW'(q[i].cnt)) begin
                bad++; $display("FAIL add_sub cyc=%0d err/cnt got=%b/%0d want=%b/%0d", i, mem_error, retired_count, q[i].err, q[i].cnt);
            end
            @(posedge clk); #1;
        end
        q.delete();
        tot++;
        if (retired_count !== 2'd2) begin bad++; $display("FAIL add_sub_count got=%0d want=2", retired_count); end
    endtask

    task automatic test_load();
        do_reset();
        push(1'b1, 1'b0, 4'd0, 1'b0, 10'd0);
        model_instr(LOAD, 0, 3, 1'b1);
        push(1'b1, 1'b0, 4'd0, 1'b1, ov(1,0,0,0,0,0,2'b00,1,0));
        foreach (q[i]) begin
            run = q[i].run; fetch_valid = q[i].fv; fetch_opcode = q[i].op; mem_ack = q[i].ack;
            @(negedge clk);
            tot++;
            if (outs !== q[i].o) begin bad++; $display("FAIL load cyc=%0d strobes got=%b want=%b", i, outs, q[i].o); end
            tot++;
            if (mem_error !== q[i].err || retired_count !== CW'(q[i].cnt)) begin
                bad++; $display("FAIL load cyc=%0d err/cnt got=%b/%0d want=%b/%0d", i, mem_error, retired_count, q[i].err, q[i].cnt);
            end
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    task automatic test_store_timeout();
        do_reset();
        push(1'b1, 1'b0, 4'd0, 1'b0, 10'd0);
        model_instr(ADD, 0, 1, 1'b1);
        model_instr(STORE, 1, TO + 1, 1'b1);
        repeat (3) push(1'b1, 1'b1, rop(), 1'b1, ov(0,0,0,0,0,0,2'b00,0,1));
        foreach (q[i]) begin
            run = q[i].run; fetch_valid = q[i].fv; fetch_opcode = q[i].op; mem_ack = q[i].ack;
            @(negedge clk);
            tot++;
            if (outs !== q[i].o) begin bad++; $display("FAIL store_timeout cyc=%0d strobes got=%b want=%b", i, outs, q[i].o); end
            tot++;
            if (mem_error !== q[i].err || retired_count !== CW'(q[i].cnt)) begin
                bad++; $display("FAIL store_timeout cyc=%0d err/cnt got=%b/%0d want=%b/%0d", i, mem_error, retired_count, q[i].err, q[i].cnt);
            end
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    task automatic test_li_nop_halt();
        do_reset();
        push(1'b1, 1'b0, 4'd0, 1'b0, 10'd0);
        model_instr(LI, 0, 1, 1'b1);
        model_instr(4'b0111, 0, 1, 1'b1);
        model_instr(HALT, 1, 1, 1'b1);
        repeat (4) push(1'b1, 1'b1, rop(), rb(), ov(0,0,0,0,0,0,2'b00,0,1));
        foreach (q[i]) begin
            run = q[i].run; fetch_valid = q[i].fv; fetch_opcode = q[i].op; mem_ack = q[i].ack;
            @(negedge clk);
            tot++;
            if (outs !== q[i].o) begin bad++; $display("FAIL li_nop_halt cyc=%0d strobes got=%b want=%b", i, outs, q[i].o); end
            tot++;
            if (mem_error !== q[i].err || retired_count !== CW'(q[i].cnt)) begin
                bad++; $display("FAIL li_nop_halt cyc=%0d err/cnt got=%b/%0d want=%b/%0d", i, mem_error, retired_count, q[i].err, q[i].cnt);
            end
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        push(1'b1, 1'b0, 4'd0, 1'b0, 10'd0);
        model_instr(ADD, 0, 1, 1'b1);
        model_instr(LOAD, 0, TO + 1, 1'b1);
        // play up to and including MEM cycle 1 (IDLE + 4 ADD + F, D, E, M1)
        for (int i = 0; i < 9; i++) begin
            run = q[i].run; fetch_valid = q[i].fv; fetch_opcode = q[i].op; mem_ack = q[i].ack;
            @(negedge clk);
            tot++;
            if (outs !== q[i].o) begin bad++; $display("FAIL mid_mem_pre cyc=%0d strobes got=%b want=%b", i, outs, q[i].o); end
            @(posedge clk); #1;
        end
        q.delete();
        mem_ack = 1'b0;
        #1;
        tot++;
        if (mem_read !== 1'b1 || retired_count !== 2'd1) begin
            bad++; $display("FAIL mid_mem_m2 rd/cnt got=%b/%0d want=1/1", mem_read, retired_count);
        end
        reset = 1'b1;
        #1;
        tot++;
        if (outs !== 10'd0 || retired_count !== 2'd0 || mem_error !== 1'b0) begin
            bad++; $display("FAIL mid_mem_async got=%b/%0d/%b want=0/0/0", outs, retired_count, mem_error);
        end
        @(posedge clk); #1;
        run = 1'b1; fetch_valid = 1'b1; fetch_opcode = ADD;
        reset = 1'b0;
        @(negedge clk);
        tot++;
        if (outs !== 10'd0 || retired_count !== 2'd0) begin
            bad++; $display("FAIL mid_mem_idle got=%b/%0d want=0/0", outs, retired_count);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tot++;
        if (outs !== ov(1,0,0,0,0,0,2'b00,1,0)) begin
            bad++; $display("FAIL mid_mem_refetch got=%b want=%b", outs, ov(1,0,0,0,0,0,2'b00,1,0));
        end
    endtask

    task automatic test_wrap();
        int expv[5] = '{1, 2, 3, 0, 1};
        do_reset();
        run = 1'b1; fetch_valid = 1'b1; fetch_opcode = ADD; mem_ack = 1'b0;
        @(posedge clk);
        for (int n = 0; n < 5; n++) begin
            repeat (4) @(posedge clk);
            #1;
            tot++;
            if (retired_count !== CW'(expv[n]) || fetch_req !== 1'b1) begin
                bad++; $display("FAIL wrap n=%0d cnt/fetch got=%0d/%b want=%0d/1", n, retired_count, fetch_req, expv[n]);
            end
        end
    endtask

    task automatic test_random();
        for (int rnd = 0; rnd < 4; rnd++) begin
            do_reset();
            push(1'b1, rb(), rop(), rb(), 10'd0);
            for (int n = 0; n < 25 && !m_halt; n++) begin
                bit [3:0] op;
                int       fw, ackk;
                bit       r;
                op = rop();
                if (op == HALT && $urandom_range(0, 3) != 0) op = ADD;
                fw   = $urandom_range(0, 2);
                ackk = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(1, TO);
                r    = ($urandom_range(0, 3) != 0);
                model_instr(op, fw, ackk, r);
                if (!m_halt && !r) begin
                    repeat ($urandom_range(0, 2)) push(1'b0, rb(), rop(), rb(), 10'd0);
                    push(1'b1, rb(), rop(), rb(), 10'd0);
                end
            end
            if (m_halt) repeat (3) push(1'b1, 1'b1, rop(), 1'b1, ov(0,0,0,0,0,0,2'b00,0,1));
            foreach (q[i]) begin
                run = q[i].run; fetch_valid = q[i].fv; fetch_opcode = q[i].op; mem_ack = q[i].ack;
                @(negedge clk);
                tot++;
                if (outs !== q[i].o) begin bad++; $display("FAIL random r=%0d cyc=%0d strobes got=%b want=%b", rnd, i, outs, q[i].o); end
                tot++;
                if (mem_error !== q[i].err || retired_count !== CW'(q[i].cnt)) begin
                    bad++; $display("FAIL random r=%0d cyc=%0d err/cnt got=%b/%0d want=%b/%0d", rnd, i, mem_error, retired_count, q[i].err, q[i].cnt);
                end
                @(posedge clk); #1;
            end
            q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_sub();
        test_load();
        test_store_timeout();
        test_li_nop_halt();
        test_reset_mid_mem();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the 4-bit-opcode datapath. It fetches one opcode per instruction over a valid/request handshake and walks it through decode, execute, memory and write-back states. In each state it drives the datapath strobes (reg_write_enable, alu_op, mem_read, mem_write, mux_sel). It sits between instruction memory, data memory and the register-file/ALU datapath, and counts retired instructions.

## Interface
- MEM_TIMEOUT, 15: maximum cycles spent in MEM waiting for mem_ack; must be ≥1.
- CNT_W, 16: width of retired_count.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; all state and outputs clear immediately.
- run  in  1  level; enables leaving IDLE and starting the next instruction after retire.
- fetch_req  out  1  opcode request to instruction memory.
- fetch_valid  in  1  fetch_opcode is valid this cycle.
- fetch_opcode  in  4  instruction opcode.
- mem_ack  in  1  data-memory access complete.
- reg_write_enable  out  1  register-file write strobe.
- alu_op  out  1  0 = add, 1 = sub.
- mem_read  out  1  data-memory read request.
- mem_write  out  1  data-memory write request.
- mux_sel  out  2  write-back source: 00 = ALU, 01 = memory, 10 = immediate.
- pc_inc  out  1  one-cycle PC increment pulse.
- busy  out  1  state ≠ IDLE and state ≠ HALT.
- halted  out  1  in HALT.
- mem_error  out  1  sticky; set on memory timeout.
- retired_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

## Operation
- Opcodes:
  - 0000 ADD
  - 0001 SUB
  - 0010 LOAD
  - 0011 STORE
  - 0100 LI
  - 1111 HALT
  - all others are NOP.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE → FETCH when run = 1.
- FETCH: fetch_req = 1. On fetch_valid, latch fetch_opcode into the IR, then go to DECODE. Otherwise stay in FETCH.
- DECODE: pc_inc = 1 for exactly this cycle. Next state is EXEC.
- EXEC, by opcode:
  - ADD, SUB, LI: drive alu_op per opcode, then WB.
  - LOAD, STORE: alu_op = 0 (address add), mux_sel = 00, then MEM.
  - NOP: retire.
  - HALT: go to HALT (not counted as retired).
- MEM:
  - LOAD holds mem_read = 1; STORE holds mem_write = 1.
  - The wait counter clears on MEM entry and increments each cycle without an ack.
  - mem_ack in MEM cycle k, where 1 ≤ k ≤ MEM_TIMEOUT: LOAD → WB; STORE retires.
  - No ack by cycle MEM_TIMEOUT: set mem_error = 1 and go to HALT.
- WB: reg_write_enable = 1 for one cycle. mux_sel is ADD/SUB → 00, LOAD → 01, LI → 10; alu_op is held per opcode. Then retire.
- Retire: retired_count increments on the leaving edge; next state is FETCH if run = 1, else IDLE.
- run deasserting mid-instruction does not abort; it only takes effect at retire.
- HALT is absorbing until reset.
- fetch_valid outside FETCH and mem_ack outside MEM are ignored.

## Timing
- Control outputs are Moore decodes of state plus IR. Outputs not named for a state are 0.
- Reset values: all outputs 0, state IDLE, IR 0, retired_count 0, mem_error 0.
- Minimum latency from FETCH entry with fetch_valid already high to next FETCH:
  - ADD/SUB/LI: 4 cycles.
  - NOP: 3 cycles.
  - STORE: 3 + k cycles.
  - LOAD: 4 + k cycles.
- fetch_valid and mem_ack are sampled on the same edge that changes state.
- Reset asserted mid-MEM drops mem_read/mem_write asynchronously; no access completes.
- retired_count wrap: 2^CNT_W − 1 → 0 with no flag.

## Structure
- Package seq_pkg contains:
  - opcode localparams;
  - state enum (3 bits);
  - MUX_ALU/MUX_MEM/MUX_IMM constants;
  - op_class enum (ALU, LOAD, STORE, LI, NOP, HALT).
- Sub-module op_decode: combinational, IR → op_class, alu_op, wb mux_sel. The sequencer FSM, wait counter and retire counter stay in the top module.

## Test plan
- ADD then SUB, fetch_valid always high, run = 1:
  - pc_inc in cycles 2 and 6;
  - reg_write_enable in cycles 4 and 8, with alu_op 0 then 1;
  - retired_count = 2.
- LOAD with mem_ack in MEM cycle 3:
  - mem_read high for exactly 3 cycles;
  - then one WB cycle with mux_sel = 01;
  - retired_count increments.
- STORE with no mem_ack, MEM_TIMEOUT = 4:
  - mem_write high for 4 cycles;
  - then mem_error = 1, halted = 1, retired_count unchanged, outputs 0.
- LI, NOP 0111, then HALT:
  - LI's WB has mux_sel = 10; NOP takes 3 cycles with no strobes;
  - HALT sets halted = 1, and the FSM stays there despite run and fetch_valid.
- Reset asserted in MEM cycle 2 of a LOAD: all outputs 0 immediately; after release the FSM is in IDLE with count 0.
- CNT_W = 2, five ADDs: retired_count reads 1, 2, 3, 0, 1.
